// File: rtl/peak_scanner.sv
`default_nettype none
// ============================================================================
// Module   : peak_scanner
// Brief    : Raster-scans a 2-D signed score map and reports the in-band peak.
// Revision : 1.0 - initial release
// ============================================================================
module peak_scanner #(
  parameter int DATA_W   = 8,
  parameter int MAP_W    = 32,
  parameter int MAP_H    = 32,
  parameter int RD_LAT   = 1,
  parameter int BORDER   = 0,
  parameter int TIE_LAST = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic signed [DATA_W-1:0]               threshold,
  output logic                                   rd_en,
  output logic [$clog2(MAP_W)+$clog2(MAP_H)-1:0] raddr,
  input  logic signed [DATA_W-1:0]               rdata,
  output logic                                   busy,
  output logic                                   peak_ready,
  output logic                                   peak_found,
  output logic [$clog2(MAP_W)-1:0]               peak_u,
  output logic [$clog2(MAP_H)-1:0]               peak_v,
  output logic signed [DATA_W-1:0]               peak_val
);

  localparam int U_W    = $clog2(MAP_W);
  localparam int V_W    = $clog2(MAP_H);
  localparam int ADDR_W = U_W + V_W;

  localparam logic [U_W-1:0] c_u_last     = U_W'(MAP_W - 1);
  localparam logic [V_W-1:0] c_v_last     = V_W'(MAP_H - 1);
  localparam logic [1:0]     c_drain_last = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [U_W-1:0]           r_u;
  logic [V_W-1:0]           r_v;
  logic [1:0]               r_drain_cnt;
  logic signed [DATA_W-1:0] r_thr;
  logic signed [DATA_W-1:0] r_max;
  logic [U_W-1:0]           r_max_u;
  logic [V_W-1:0]           r_max_v;
  logic                     r_max_vld;
  logic                     r_pipe_vld [RD_LAT];
  logic [U_W-1:0]           r_pipe_u   [RD_LAT];
  logic [V_W-1:0]           r_pipe_v   [RD_LAT];
  logic                     r_peak_ready;
  logic                     r_peak_found;
  logic [U_W-1:0]           r_peak_u;
  logic [V_W-1:0]           r_peak_v;
  logic signed [DATA_W-1:0] r_peak_val;

  int   w_u_i;
  int   w_v_i;
  logic w_in_band;
  logic w_last_addr;
  logic w_start_acc;
  logic w_abort_acc;
  logic w_better;

  assign w_u_i       = int'(r_u);
  assign w_v_i       = int'(r_v);
  assign w_in_band   = (w_u_i >= BORDER) && (w_u_i < MAP_W - BORDER) &&
                       (w_v_i >= BORDER) && (w_v_i < MAP_H - BORDER);
  assign w_last_addr = (r_u == c_u_last) && (r_v == c_v_last);
  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_abort_acc = abort && ((r_state == S_SCAN) || (r_state == S_DRAIN));
  assign w_better    = (TIE_LAST != 0) ? (rdata >= r_max) : (rdata > r_max);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    raddr       = '0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_SCAN;
      S_SCAN: begin
        rd_en = 1'b1;
        raddr = ADDR_W'({r_v, r_u});
        busy  = 1'b1;
        if (abort)            w_state_nxt = S_IDLE;
        else if (w_last_addr) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (abort)                             w_state_nxt = S_IDLE;
        else if (r_drain_cnt == c_drain_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Issue counters; raddr is the {v,u} concatenation since both dims are powers of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_u         <= '0;
      r_v         <= '0;
      r_thr       <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_start_acc) begin
        r_u   <= '0;
        r_v   <= '0;
        r_thr <= threshold;
      end else if (r_state == S_SCAN) begin
        r_u <= r_u + U_W'(1);
        if (r_u == c_u_last) r_v <= r_v + V_W'(1);
      end
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 2'd1;
      else                    r_drain_cnt <= '0;
    end
  end

  // Coordinate pipeline aligned with the memory latency; abort flushes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_u[i]   <= '0;
        r_pipe_v[i]   <= '0;
      end
    end else begin
      r_pipe_vld[0] <= (r_state == S_SCAN) && w_in_band && !w_abort_acc;
      r_pipe_u[0]   <= r_u;
      r_pipe_v[0]   <= r_v;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1] && !w_abort_acc;
        r_pipe_u[i]   <= r_pipe_u[i-1];
        r_pipe_v[i]   <= r_pipe_v[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_max     <= '0;
      r_max_u   <= '0;
      r_max_v   <= '0;
      r_max_vld <= 1'b0;
    end else if (w_start_acc) begin
      r_max_vld <= 1'b0;
    end else if (r_pipe_vld[RD_LAT-1] && !w_abort_acc && (!r_max_vld || w_better)) begin
      r_max     <= rdata;
      r_max_u   <= r_pipe_u[RD_LAT-1];
      r_max_v   <= r_pipe_v[RD_LAT-1];
      r_max_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak_ready <= 1'b0;
      r_peak_found <= 1'b0;
      r_peak_u     <= '0;
      r_peak_v     <= '0;
      r_peak_val   <= '0;
    end else begin
      r_peak_ready <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_peak_found <= (r_max >= r_thr);
        r_peak_u     <= r_max_u;
        r_peak_v     <= r_max_v;
        r_peak_val   <= r_max;
      end
    end
  end

  assign peak_ready = r_peak_ready;
  assign peak_found = r_peak_found;
  assign peak_u     = r_peak_u;
  assign peak_v     = r_peak_v;
  assign peak_val   = r_peak_val;

endmodule
`default_nettype wire
